// File: rtl/uart_tx_fifo_pkg.sv
// uart_pkg: drain FSM state encoding and frame width shared with the uart integration
package uart_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} tx_drain_state_t;
   localparam int UART_DATA_W = 8;
endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: host write port, FIFO status and uart frame handshake
interface uart_tx_fifo_if
   import uart_pkg::*;
#(
   parameter int DATA_W = UART_DATA_W,
   parameter int DEPTH = 16,
   parameter int CNT_W = $clog2(DEPTH) + 1
);
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              full;
   logic              empty;
   logic [CNT_W-1:0]  count;
   logic              overflow;
   logic [DATA_W-1:0] data_frame_in;
   logic              tx_start;
   logic              tx_busy;
   modport master (
      output wr_en, wr_data, tx_busy,
      input  full, empty, count, overflow, data_frame_in, tx_start
   );
   modport slave (
      input  wr_en, wr_data, tx_busy,
      output full, empty, count, overflow, data_frame_in, tx_start
   );
endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// uart_sync_fifo: synchronous FIFO with extra pointer MSB separating full from empty
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int DATA_W = UART_DATA_W,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en_i,
   input  logic [DATA_W-1:0]      wr_data_i,
   input  logic                   rd_en_i,
   output logic [DATA_W-1:0]      rd_data_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int AW = $clog2(DEPTH);
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic wr_acc;
   assign wr_acc = wr_en_i && !full_o;
   assign wr_ptr_d = wr_ptr_q + (AW+1)'(wr_acc);
   assign rd_ptr_d = rd_ptr_q + (AW+1)'(rd_en_i && !empty_o);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   always_ff @(posedge clk)
      if (wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
   assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
   assign count_o = wr_ptr_q - rd_ptr_q;
   assign empty_o = wr_ptr_q == rd_ptr_q;
   assign full_o = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: host byte FIFO drained one frame at a time into the uart transmitter
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_W = UART_DATA_W,
   parameter int DEPTH = 16,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input logic           clk,
   input logic           rst,
   uart_tx_fifo_if.slave bus
);
   tx_drain_state_t state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d, rd_data;
   logic overflow_q, overflow_d, full, empty, pop;
   logic [CNT_W-1:0] count;
   uart_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (bus.wr_en),
      .wr_data_i (bus.wr_data),
      .rd_en_i   (pop),
      .rd_data_o (rd_data),
      .full_o    (full),
      .empty_o   (empty),
      .count_o   (count)
   );
   always_comb begin
      state_d = state_q;
      pop = 1'b0;
      case (state_q)
         IDLE: if (!empty && !bus.tx_busy) begin
            state_d = LOAD;
            pop = 1'b1;
         end
         LOAD:      state_d = WAIT_BUSY;
         WAIT_BUSY: if (bus.tx_busy) state_d = WAIT_DONE;
         WAIT_DONE: if (!bus.tx_busy) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end
   assign data_d = pop ? rd_data : data_q;
   assign overflow_d = overflow_q | (bus.wr_en & full);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         data_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q <= data_d;
         overflow_q <= overflow_d;
      end
   // decoded from the state register so reset drops the request without waiting for a clock
   assign bus.tx_start = (state_q == LOAD) || (state_q == WAIT_BUSY);
   assign bus.data_frame_in = data_q;
   assign bus.overflow = overflow_q;
   assign bus.full = full;
   assign bus.empty = empty;
   assign bus.count = count;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: table vectors plus frame scoreboard against a tx_busy uart model
module tb_uart_tx_fifo;
   import uart_pkg::*;
   logic clk, rst;
   int n_assert = 0, n_fail = 0;
   int busy_len = 3, peak = 0, frames = 0;
   bit hold_busy = 0;
   logic [7:0] q[$];
   typedef struct {
      logic       wr_en;
      logic [7:0] data;
      bit         push;
      logic       full;
      logic       empty;
      int         count;
      logic       ovf;
   } vec_t;
   vec_t vec [17];

   uart_tx_fifo_if #(.DATA_W(8), .DEPTH(16)) bus ();
   uart_tx_fifo #(.DATA_W(8), .DEPTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_assert++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic write(input logic [7:0] d, input bit push);
      bus.wr_en = 1;
      bus.wr_data = d;
      @(negedge clk);
      bus.wr_en = 0;
      if (push) q.push_back(d);
   endtask

   task automatic wait_idle(input string name, input int budget);
      bit ok = 0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         ok = (q.size() == 0) && !bus.tx_busy && !bus.tx_start && bus.empty;
      end
      chk(name, int'(ok), 1);
   endtask

   // uart model: answers each tx_start with a busy pulse of busy_len cycles and scores the frame
   initial begin
      int age;
      bit held;
      age = 0;
      held = 0;
      bus.tx_busy = 0;
      forever begin
         @(negedge clk);
         #1;
         if (hold_busy) begin
            bus.tx_busy = 1;
            held = 1;
         end else if (held) begin
            bus.tx_busy = 0;
            held = 0;
         end else if (bus.tx_busy) begin
            age++;
            if (age >= 2) chk("start_during_frame", int'(bus.tx_start), 0);
            if (age >= busy_len) bus.tx_busy = 0;
         end else if (bus.tx_start) begin
            chk("frame_expected", int'(q.size() > 0), 1);
            if (q.size() > 0) chk("frame_data", int'(bus.data_frame_in), int'(q.pop_front()));
            frames++;
            bus.tx_busy = 1;
            age = 0;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (int'(bus.count) > peak) peak = int'(bus.count);
   end

   initial begin
      int f0;
      for (int i = 0; i < 16; i++)
         vec[i] = '{1'b1, 8'(8'h10 + i), 1'b1, 1'(i == 15), 1'b0, i + 1, 1'b0};
      vec[16] = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 16, 1'b1};
      rst = 1;
      bus.wr_en = 0;
      bus.wr_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_full", int'(bus.full), 0);
      chk("rst_empty", int'(bus.empty), 1);
      chk("rst_count", int'(bus.count), 0);
      chk("rst_overflow", int'(bus.overflow), 0);
      chk("rst_data", int'(bus.data_frame_in), 0);
      chk("rst_tx_start", int'(bus.tx_start), 0);
      rst = 0;
      @(negedge clk);

      busy_len = 3;
      write(8'h37, 1);
      chk("lat_count1", int'(bus.count), 1);
      chk("lat_empty", int'(bus.empty), 0);
      chk("lat_no_start_yet", int'(bus.tx_start), 0);
      @(negedge clk);
      chk("lat_tx_start", int'(bus.tx_start), 1);
      chk("lat_data", int'(bus.data_frame_in), 8'h37);
      chk("lat_count0", int'(bus.count), 0);
      wait_idle("single_drain", 100);

      busy_len = 20;
      peak = 0;
      f0 = frames;
      write(8'h37, 1);
      write(8'h49, 1);
      write(8'hA5, 1);
      wait_idle("burst_drain", 300);
      chk("burst_frames", frames - f0, 3);
      chk("burst_peak", peak, 2);

      busy_len = 3;
      hold_busy = 1;
      repeat (2) @(negedge clk);
      foreach (vec[i]) begin
         bus.wr_en = vec[i].wr_en;
         bus.wr_data = vec[i].data;
         @(negedge clk);
         bus.wr_en = 0;
         if (vec[i].push) q.push_back(vec[i].data);
         chk($sformatf("fill%0d_full", i), int'(bus.full), int'(vec[i].full));
         chk($sformatf("fill%0d_empty", i), int'(bus.empty), int'(vec[i].empty));
         chk($sformatf("fill%0d_count", i), int'(bus.count), vec[i].count);
         chk($sformatf("fill%0d_ovf", i), int'(bus.overflow), int'(vec[i].ovf));
      end
      f0 = frames;
      hold_busy = 0;
      wait_idle("full_drain", 600);
      chk("full_frames", frames - f0, 16);
      chk("overflow_sticky", int'(bus.overflow), 1);

      busy_len = 2;
      f0 = frames;
      hold_busy = 1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) write(8'(8'hA0 + i), 1);
      chk("pre_simul_count", int'(bus.count), 3);
      hold_busy = 0;
      write(8'hA3, 1);
      chk("simul_count", int'(bus.count), 3);
      for (int i = 4; i < 20; i++) begin
         write(8'(8'hA0 + i), 1);
         repeat (4) @(negedge clk);
      end
      wait_idle("wrap_drain", 400);
      chk("wrap_frames", frames - f0, 20);

      busy_len = 30;
      for (int i = 0; i < 6; i++) write(8'(8'hC0 + i), 1);
      begin
         bit seen = 0;
         for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = bus.tx_busy && !bus.tx_start;
         end
         chk("reach_wait_done", int'(seen), 1);
      end
      chk("queued_before_reset", int'(bus.count), 5);
      rst = 1;
      #2;
      chk("mid_rst_tx_start", int'(bus.tx_start), 0);
      chk("mid_rst_empty", int'(bus.empty), 1);
      chk("mid_rst_count", int'(bus.count), 0);
      chk("mid_rst_overflow", int'(bus.overflow), 0);
      q.delete();
      f0 = frames;
      repeat (2) @(negedge clk);
      rst = 0;
      repeat (100) @(negedge clk);
      chk("no_frame_after_reset", frames - f0, 0);
      chk("post_rst_empty", int'(bus.empty), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit-side buffer placed directly upstream of the `uart` block. A host writes bytes at full clock rate into a synchronous FIFO. A drain state machine presents one byte at a time on `data_frame_in` of the `uart` instance and handshakes each frame through `tx_start`/`tx_busy`, so back-to-back host bytes are serialised without loss. It decouples bursty producers from the slow serial line and reports overflow.

## Interface
Parameters:
- `DATA_W`, 8: frame width; must match the `uart` data frame.
- `DEPTH`, 16: FIFO entries; a power of two, ≥2.
- `CNT_W`, $clog2(DEPTH)+1: width of `count`.

Ports:
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `wr_en`  in  1: host write strobe.
- `wr_data`  in  DATA_W: host byte, sampled when `wr_en`=1.
- `full`  out  1: FIFO holds DEPTH entries.
- `empty`  out  1: FIFO holds 0 entries.
- `count`  out  CNT_W: current occupancy, 0..DEPTH.
- `overflow`  out  1: sticky; a write was attempted while full.
- `data_frame_in`  out  DATA_W: byte to the `uart` transmitter; registered.
- `tx_start`  out  1: frame request to the `uart`.
- `tx_busy`  in  1: high while the `uart` is shifting a frame.

## Operation
- Write accept: `wr_en && !full`. The byte is stored at `wr_ptr`, and `wr_ptr` increments modulo DEPTH. A pointer MSB extra bit distinguishes full from empty.
- Write while full: data is dropped, pointers are unchanged, and `overflow` is set to 1. `overflow` clears only on `rst`.
- Drain FSM states: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
- IDLE → LOAD when `!empty && !tx_busy`. On that edge the head entry is popped: `data_frame_in <= mem[rd_ptr]`, and `rd_ptr` increments.
- LOAD: `tx_start`=1. Next state is WAIT_BUSY.
- WAIT_BUSY: `tx_start` is held at 1 until `tx_busy`=1 is sampled, then the FSM goes to WAIT_DONE. This is a level handshake with no timeout.
- WAIT_DONE: `tx_start`=0. The FSM waits for `tx_busy`=0, then returns to IDLE.
- `data_frame_in` holds its value from the pop until the next pop, so it is stable for the entire frame.
- Simultaneous write and pop in one cycle: both take effect. `count` is unchanged, and the pointers both advance.
- Wrap-around: both pointers roll from DEPTH-1 to 0. The data order is strictly FIFO.
- Reset mid-frame: FIFO contents are discarded and the FSM returns to IDLE. `tx_start` drops asynchronously; the `uart` may finish the frame in flight.

## Timing
- Reset values: `full`=0, `empty`=1, `count`=0, `overflow`=0, `data_frame_in`=0, `tx_start`=0. Both pointers and the state (IDLE) are also reset.
- `full`, `empty` and `count` are registered and reflect every accept or pop one edge later. A write in the cycle that follows a pop from a full FIFO is accepted.
- Latency with an empty FIFO and an idle `uart`:
  - Write accepted at edge N.
  - `empty`=0 after edge N.
  - Pop at edge N+1.
  - `tx_start`=1 and the new `data_frame_in` are visible in the cycle after edge N+1, i.e. 2 cycles after the write.
- Minimum spacing between frames: pop, then ≥1 cycle of `tx_start`, then the `tx_busy` high period, then 1 idle cycle.
- Throughput is one frame per `uart` frame time. The FIFO absorbs bursts of up to DEPTH bytes.

## Structure
- Package `uart_pkg`:
  - `typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} tx_drain_state_t`.
  - `localparam UART_DATA_W = 8`, shared with the `uart` integration.
- Sub-module `uart_sync_fifo`:
  - Parameterised by DATA_W and DEPTH.
  - Owns the storage array, pointers, `full`, `empty` and `count`.
  - Exposes a `rd_en`/`rd_data` pop port.
- Top `uart_tx_fifo` holds the drain FSM, the `data_frame_in` register and the `overflow` flag.

## Test plan
- Reset, then write 8'h37 with `tx_busy` tied to a model: `tx_start` rises 2 cycles after the write, `data_frame_in`=8'h37, and `count` goes 1→0.
- Burst-write 8'h37, 8'h49, 8'hA5 in consecutive cycles while the model holds `tx_busy` for 20 cycles per frame: frames go out in order 37, 49, A5, each `tx_start` only after the previous `tx_busy` falls, and `count` peaks at 2.
- Fill DEPTH=16 entries while `tx_busy`=1 permanently, then write 8'hFF: `full`=1, `count`=16, `overflow`=1, and 8'hFF never appears on `data_frame_in`.
- Simultaneous write and pop at `count`=3: `count` stays 3 and the pointer wrap past index 15 preserves order across 20 total bytes.
- Assert `rst` during WAIT_DONE with 5 bytes queued: immediately `tx_start`=0, `empty`=1, `count`=0 and `overflow`=0, and no further frames are requested after release.
